// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_stage
//  Description : Instruction fetch stage with variable-latency imem handshake,
//                one-entry decode hold buffer, flush/squash and HLT detection.
//                Optional macro FETCH_PERF_CNT_EN adds stall/squash counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage #(
    parameter int                 ADDR_W    = 16,
    parameter int                 INSTR_W   = 16,
    parameter logic [INSTR_W-1:0] NOP_INSTR = 16'h0000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [ADDR_W-1:0]  pc,
    input  logic [ADDR_W-1:0]  pc_plus_two,
    input  logic               flush,
    input  logic               decode_stall,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ready,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               stall_pc,
    output logic [INSTR_W-1:0] if_id_instr,
    output logic [ADDR_W-1:0]  if_id_pc_plus_two,
    output logic               if_id_valid,
    output logic               halted
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [15:0]        fetch_stall_cycles,
    output logic [15:0]        squash_count
`endif
);

    localparam logic [2:0] c_ST_IDLE    = 3'd0;
    localparam logic [2:0] c_ST_FETCH   = 3'd1;
    localparam logic [2:0] c_ST_HOLD    = 3'd2;
    localparam logic [2:0] c_ST_DISCARD = 3'd3;
    localparam logic [2:0] c_ST_HALT    = 3'd4;
    localparam logic [3:0] c_HLT_OPCODE = 4'hF;

    logic [2:0]         r_state;
    logic [INSTR_W-1:0] r_if_id_instr;
    logic [ADDR_W-1:0]  r_if_id_pc2;
    logic               r_if_id_valid;
    logic [INSTR_W-1:0] r_hold_instr;
    logic [ADDR_W-1:0]  r_hold_pc2;

    logic w_xfer;
    logic w_rdata_is_hlt;
    logic w_hold_is_hlt;

    assign w_xfer         = imem_req & imem_ready;
    assign w_rdata_is_hlt = (imem_rdata[INSTR_W-1 -: 4] == c_HLT_OPCODE);
    assign w_hold_is_hlt  = (r_hold_instr[INSTR_W-1 -: 4] == c_HLT_OPCODE);

    assign imem_addr         = pc;
    assign halted            = (r_state == c_ST_HALT);
    assign if_id_instr       = r_if_id_instr;
    assign if_id_pc_plus_two = r_if_id_pc2;
    assign if_id_valid       = r_if_id_valid;

    always_comb begin
        imem_req = (r_state == c_ST_FETCH) || (r_state == c_ST_DISCARD);
        stall_pc = 1'b1;
        if (flush) begin
            // Release the PC so it can take the redirect target this cycle.
            stall_pc = 1'b0;
        end else begin
            case (r_state)
                c_ST_FETCH: stall_pc = ~(w_xfer & ~decode_stall);
                c_ST_HOLD:  stall_pc = decode_stall;
                default:    stall_pc = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= c_ST_IDLE;
            r_if_id_instr <= NOP_INSTR;
            r_if_id_pc2   <= '0;
            r_if_id_valid <= 1'b0;
            r_hold_instr  <= NOP_INSTR;
            r_hold_pc2    <= '0;
        end else if (flush) begin
            r_if_id_instr <= NOP_INSTR;
            r_if_id_valid <= 1'b0;
            r_hold_instr  <= NOP_INSTR;
            r_hold_pc2    <= '0;
            // A request still waiting on memory must have its late data dropped.
            r_state       <= (r_state == c_ST_FETCH && !w_xfer) ? c_ST_DISCARD : c_ST_FETCH;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (!decode_stall) r_if_id_valid <= 1'b0;
                    r_state <= c_ST_FETCH;
                end
                c_ST_FETCH: begin
                    if (w_xfer) begin
                        if (!decode_stall) begin
                            r_if_id_instr <= imem_rdata;
                            r_if_id_pc2   <= pc_plus_two;
                            r_if_id_valid <= 1'b1;
                            r_state       <= w_rdata_is_hlt ? c_ST_HALT : c_ST_FETCH;
                        end else begin
                            r_hold_instr <= imem_rdata;
                            r_hold_pc2   <= pc_plus_two;
                            r_state      <= c_ST_HOLD;
                        end
                    end else if (!decode_stall) begin
                        r_if_id_valid <= 1'b0;
                    end
                end
                c_ST_HOLD: begin
                    if (!decode_stall) begin
                        r_if_id_instr <= r_hold_instr;
                        r_if_id_pc2   <= r_hold_pc2;
                        r_if_id_valid <= 1'b1;
                        r_state       <= w_hold_is_hlt ? c_ST_HALT : c_ST_FETCH;
                    end
                end
                c_ST_DISCARD: begin
                    if (!decode_stall) r_if_id_valid <= 1'b0;
                    if (imem_ready) r_state <= c_ST_FETCH;
                end
                c_ST_HALT: begin
                    if (!decode_stall) r_if_id_valid <= 1'b0;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [15:0] r_fetch_stall_cycles;
    logic [15:0] r_squash_count;
    logic        w_stall_inc;
    logic        w_squash_inc;

    assign w_stall_inc  = ((r_state == c_ST_FETCH) && imem_req && !imem_ready) ||
                          (r_state == c_ST_DISCARD);
    assign w_squash_inc = flush && (r_if_id_valid || imem_req);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fetch_stall_cycles <= '0;
            r_squash_count       <= '0;
        end else begin
            if (w_stall_inc && (r_fetch_stall_cycles != 16'hFFFF))
                r_fetch_stall_cycles <= r_fetch_stall_cycles + 16'd1;
            if (w_squash_inc && (r_squash_count != 16'hFFFF))
                r_squash_count <= r_squash_count + 16'd1;
        end
    end

    assign fetch_stall_cycles = r_fetch_stall_cycles;
    assign squash_count       = r_squash_count;
`endif

endmodule
`default_nettype wire
